// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (read-only) and data (load/store).
// Latency: request seen in IDLE at cycle R -> mem_en at R+1, done at R+MEM_LAT+2; one access every MEM_LAT+3 cycles.
// Backpressure: requesters hold req until their done pulse; stall lines are req & ~done.
//
// Ports:
//   clk, rst          clock and asynchronous active-low reset
//   if_*              fetch requester: req/addr in, rdata/done/stall out
//   d_*               data requester: req/wr/addr/wdata in, rdata/done/stall out
//   mem_*             memory port: en/wr/addr/wdata out, rdata in (valid MEM_LAT cycles after en)
//   gnt               one-hot owner {data,fetch}, 00 while idle
module mem_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    output logic          if_stall,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          d_stall,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    gnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] LAT_INIT  = 3'(MEM_LAT);
    localparam logic [2:0] SMAX      = 3'(STARVE_MAX);
    localparam logic [1:0] GNT_FETCH = 2'b01;
    localparam logic [1:0] GNT_DATA  = 2'b10;

    state_t        state_q, state_d;
    logic [2:0]    lat_q, lat_d;
    logic [2:0]    starve_q, starve_d;
    logic          wr_q, wr_d;          // latched access type, survives past ISSUE
    logic          mem_en_q, mem_en_d;
    logic          mem_wr_q, mem_wr_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          if_done_q, if_done_d;
    logic          d_done_q, d_done_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          pick_fetch;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            starve_q    <= '0;
            wr_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            gnt_q       <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            wr_q        <= wr_d;
            mem_en_q    <= mem_en_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            gnt_q       <= gnt_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        wr_d        = wr_q;
        mem_en_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        gnt_d       = gnt_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        // Data has priority unless fetch has waited through STARVE_MAX data grants.
        pick_fetch  = if_req && (!d_req || (starve_q == SMAX));

        unique case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    state_d  = ISSUE;
                    mem_en_d = 1'b1;
                    if (pick_fetch) begin
                        gnt_d       = GNT_FETCH;
                        wr_d        = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        starve_d    = '0;
                    end else begin
                        gnt_d       = GNT_DATA;
                        wr_d        = d_wr;
                        mem_wr_d    = d_wr;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        // Only data grants that overtake a waiting fetch count toward starvation.
                        if (!if_req) begin
                            starve_d = '0;
                        end else if (starve_q != SMAX) begin
                            starve_d = starve_q + 3'd1;
                        end
                    end
                end
            end
            ISSUE: begin
                lat_d   = LAT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                lat_d = lat_q - 3'd1;
                // lat_q==1 is exactly MEM_LAT cycles after the ISSUE strobe.
                if (lat_q == 3'd1) begin
                    state_d   = DONE;
                    if_done_d = gnt_q[0];
                    d_done_d  = gnt_q[1];
                    if (!wr_q) begin
                        if (gnt_q[1]) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            DONE: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_en    = mem_en_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign gnt       = gnt_q;
    assign if_done   = if_done_q;
    assign d_done    = d_done_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_stall  = if_req & ~if_done_q;
    assign d_stall   = d_req & ~d_done_q;

endmodule
